ifetch_unit: RTL

//  Instruction-fetch stage; consumes the branch-taken select (sele) and the branch target (aluout) from exe.

---
 rtl/ifetch_unit_pkg.sv | 13 +
 rtl/ifetch_unit_if.sv | 29 ++
 rtl/ifetch_unit_nextpc.sv | 28 ++
 rtl/ifetch_unit.sv | 110 +++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handoff.
interface ifetch_unit_if #(
  parameter int n = 32
);
  logic         imem_req_valid;
  logic [n-1:0] imem_req_addr;
  logic         imem_req_ready;
  logic         imem_rsp_valid;
  logic [n-1:0] imem_rsp_data;
  logic         if_valid;
  logic [n-1:0] if_instr;
  logic [n-1:0] if_pc;
  logic         dec_ready;

  // master is the fetch stage; slave is memory plus decode.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_instr, if_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_instr, if_pc,
    output dec_ready
  );
endinterface

// File: rtl/ifetch_unit_nextpc.sv
// Next-PC select: word-aligned redirect target, sequential increment, or hold.
module ifetch_unit_nextpc
  import ifetch_unit_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] pc_i,
  input  logic [n-1:0] target_i,
  input  logic         redirect_i,
  input  logic         advance_i,
  output logic [n-1:0] pc_next_o
);
  logic [n-1:0] target_aligned;
  logic [n-1:0] pc_inc;

  assign target_aligned = {target_i[n-1:2], 2'b00};
  assign pc_inc         = pc_i + n'(INSTR_BYTES);

  // Redirect always wins over the sequential step.
  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = target_aligned;
    end else if (advance_i) begin
      pc_next_o = pc_inc;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, held word handed to decode,
// taken-branch redirect squashes in-flight or held instructions.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sele,
  input  logic [n-1:0]  aluout,
  ifetch_unit_if.master bus
);
  fetch_state_t state_q;
  logic [n-1:0] pc_q;
  logic [n-1:0] pc_d;
  logic         if_valid_q;
  logic [n-1:0] if_instr_q;
  logic [n-1:0] if_pc_q;
  logic         req_valid;
  logic         req_fire;
  logic         advance;

  // Requests are suppressed whenever a redirect is present so no wrong-path address leaves.
  always_comb begin
    req_valid = 1'b0;
    unique case (state_q)
      FETCH:   req_valid = ~sele;
      HOLD:    req_valid = bus.dec_ready & ~sele;
      default: req_valid = 1'b0;
    endcase
    if (!rst_n) begin
      req_valid = 1'b0;
    end
  end

  assign req_fire = req_valid & bus.imem_req_ready;
  assign advance  = (state_q == WAIT) & bus.imem_rsp_valid;

  ifetch_unit_nextpc #(
    .n(n)
  ) u_nextpc (
    .pc_i       (pc_q),
    .target_i   (aluout),
    .redirect_i (sele),
    .advance_i  (advance),
    .pc_next_o  (pc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      pc_q <= pc_d;
      unique case (state_q)
        FETCH: begin
          if (req_fire) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (sele) begin
              state_q <= FETCH;
            end else begin
              if_instr_q <= bus.imem_rsp_data;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              state_q    <= HOLD;
            end
          end else if (sele) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (bus.imem_rsp_valid) begin
            state_q <= FETCH;
          end
        end
        HOLD: begin
          // A redirect squashes the held word even if decode is ready.
          if (sele) begin
            if_valid_q <= 1'b0;
            state_q    <= FETCH;
          end else if (bus.dec_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= req_fire ? WAIT : FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_pc          = if_pc_q;

  a_rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (state_q == WAIT || state_q == DROP)
  );
endmodule
